// File: rtl/pipe_sched.sv
// pipe_sched: round-robin issue of operand sets into a shared fixed-latency datapath.
// A tag shift register follows each issued op so its result returns with the requester ID.
module pipe_sched #(
    parameter int N    = 10,
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int LAT  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ*N-1:0] req_c,
    input  logic [NREQ*N-1:0] req_d,
    output logic [N-1:0]      pipe_a,
    output logic [N-1:0]      pipe_b,
    output logic [N-1:0]      pipe_c,
    output logic [N-1:0]      pipe_d,
    input  logic [N-1:0]      pipe_f,
    output logic              res_valid,
    output logic [IDW-1:0]    res_id,
    output logic [N-1:0]      res_data,
    output logic              busy,
    output logic [15:0]       issue_cnt
);
    logic [IDW-1:0] ptr_q, ptr_d, gnt_id;
    logic gnt_any, xfer;
    int idx;
    logic [N-1:0] pipe_a_q, pipe_a_d, pipe_b_q, pipe_b_d, pipe_c_q, pipe_c_d, pipe_d_q, pipe_d_d;
    logic [LAT:0] tag_v_q, tag_v_d;
    logic [LAT:0][IDW-1:0] tag_id_q, tag_id_d;
    logic res_valid_q, res_valid_d;
    logic [IDW-1:0] res_id_q, res_id_d;
    logic [N-1:0] res_data_q, res_data_d;
    logic [15:0] issue_cnt_q, issue_cnt_d;

    // First valid requester at or after ptr, wrapping modulo NREQ
    always_comb begin
        gnt_id = '0;
        gnt_any = 1'b0;
        idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id = IDW'(idx);
            end
        end
    end

    assign req_ready = (en && gnt_any) ? (NREQ'(1) << gnt_id) : '0;
    assign xfer = |(req_valid & req_ready);

    always_comb begin
        ptr_d = xfer ? ((int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1) : ptr_q;
        pipe_a_d = xfer ? req_a[int'(gnt_id)*N +: N] : pipe_a_q;
        pipe_b_d = xfer ? req_b[int'(gnt_id)*N +: N] : pipe_b_q;
        pipe_c_d = xfer ? req_c[int'(gnt_id)*N +: N] : pipe_c_q;
        pipe_d_d = xfer ? req_d[int'(gnt_id)*N +: N] : pipe_d_q;
        issue_cnt_d = issue_cnt_q + {15'd0, xfer};
        tag_v_d = {tag_v_q[LAT-1:0], xfer};
        tag_id_d = {tag_id_q[LAT-1:0], gnt_id};
        res_valid_d = tag_v_q[LAT];
        res_id_d = tag_v_q[LAT] ? tag_id_q[LAT] : res_id_q;
        res_data_d = tag_v_q[LAT] ? pipe_f : res_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            pipe_a_q <= '0;
            pipe_b_q <= '0;
            pipe_c_q <= '0;
            pipe_d_q <= '0;
            issue_cnt_q <= '0;
            tag_v_q <= '0;
            tag_id_q <= '0;
            res_valid_q <= 1'b0;
            res_id_q <= '0;
            res_data_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            pipe_a_q <= pipe_a_d;
            pipe_b_q <= pipe_b_d;
            pipe_c_q <= pipe_c_d;
            pipe_d_q <= pipe_d_d;
            issue_cnt_q <= issue_cnt_d;
            tag_v_q <= tag_v_d;
            tag_id_q <= tag_id_d;
            res_valid_q <= res_valid_d;
            res_id_q <= res_id_d;
            res_data_q <= res_data_d;
        end
    end

    assign pipe_a = pipe_a_q;
    assign pipe_b = pipe_b_q;
    assign pipe_c = pipe_c_q;
    assign pipe_d = pipe_d_q;
    assign res_valid = res_valid_q;
    assign res_id = res_id_q;
    assign res_data = res_data_q;
    assign issue_cnt = issue_cnt_q;
    assign busy = (|tag_v_q) || res_valid_q;
endmodule
